// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: parametrised VGA timing generator with renderer-latency
// alignment, blanking and frame-synchronous test-pattern override.
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10,
  parameter int RW       = 3,
  parameter int GW       = 3,
  parameter int BW       = 2,
  parameter int PIPE     = 0
) (
  input  logic          clk_pix,
  input  logic          rst,
  input  logic [1:0]    pattern_mode,
  input  logic [RW-1:0] pix_r,
  input  logic [GW-1:0] pix_g,
  input  logic [BW-1:0] pix_b,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          de,
  output logic          frame_start,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic [RW-1:0] vga_r,
  output logic [GW-1:0] vga_g,
  output logic [BW-1:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int HS_HI   = HS_LO + H_SYNC;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam int VS_HI   = VS_LO + V_SYNC;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW+2:0] BAR_DIV = (CW+3)'(H_ACTIVE);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [1:0]    mode;
    logic [CW-1:0] x;
    logic          yb;
  } tap_t;

  logic          run;
  logic [CW-1:0] nx;
  logic [CW-1:0] ny;
  logic [1:0]    active_mode;
  tap_t          raw_t;
  tap_t          al_t;

  // counters hold at 0,0 for the first cycle after reset so frame_start can fire
  always_comb begin
    nx = sx;
    ny = sy;
    if (run) begin
      if (sx == H_LAST) begin
        nx = '0;
        ny = (sy == V_LAST) ? '0 : sy + 1'b1;
      end else begin
        nx = sx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx          <= '0;
      sy          <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      run         <= 1'b0;
    end else begin
      sx          <= nx;
      sy          <= ny;
      de          <= (int'(nx) < H_ACTIVE) && (int'(ny) < V_ACTIVE);
      frame_start <= (nx == '0) && (ny == '0);
      run         <= 1'b1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst)
      active_mode <= 2'd0;
    else if (frame_start)
      active_mode <= pattern_mode;
  end

  always_comb begin
    raw_t      = '0;
    raw_t.hs   = (int'(sx) >= HS_LO) && (int'(sx) < HS_HI);
    raw_t.vs   = (int'(sy) >= VS_LO) && (int'(sy) < VS_HI);
    raw_t.de   = de;
    raw_t.mode = frame_start ? pattern_mode : active_mode;
    raw_t.x    = sx;
    raw_t.yb   = sy[5];
  end

  // mode travels with its pixel so a frame switches cleanly at its first pixel
  if (PIPE == 0) begin : g_nodl
    assign al_t = raw_t;
  end else begin : g_dl
    tap_t dl_q [PIPE];
    always_ff @(posedge clk_pix) begin
      if (rst) begin
        dl_q <= '{default: '0};
      end else begin
        dl_q[0] <= raw_t;
        for (int i = 1; i < PIPE; i++)
          dl_q[i] <= dl_q[i-1];
      end
    end
    assign al_t = dl_q[PIPE-1];
  end

  logic [CW+2:0] x8;
  logic [2:0]    bar;
  logic [RW-1:0] r_n;
  logic [GW-1:0] g_n;
  logic [BW-1:0] b_n;

  assign x8  = {al_t.x, 3'b000};
  assign bar = 3'(x8 / BAR_DIV);

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (al_t.de) begin
      unique case (al_t.mode)
        2'd0: begin
          r_n = pix_r;
          g_n = pix_g;
          b_n = pix_b;
        end
        2'd1: begin
          r_n = '1;
          g_n = '1;
          b_n = '1;
        end
        2'd2: begin
          r_n = {RW{bar[2]}};
          g_n = {GW{bar[1]}};
          b_n = {BW{bar[0]}};
        end
        2'd3: begin
          if (al_t.x[5] ^ al_t.yb) begin
            r_n = '1;
            g_n = '1;
            b_n = '1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      vga_hsync <= ~H_POL;
      vga_vsync <= ~V_POL;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else begin
      vga_hsync <= al_t.hs ? H_POL : ~H_POL;
      vga_vsync <= al_t.vs ? V_POL : ~V_POL;
      vga_r     <= r_n;
      vga_g     <= g_n;
      vga_b     <= b_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe: randomized scoreboard bench for vga_timing_pipe
// on a reduced raster with PIPE=3 and mixed sync polarity.
module tb_vga_timing_pipe;

  localparam int HA = 80, HFP = 8, HSW = 12, HBP = 8;
  localparam int VA = 40, VFP = 3, VSW = 2, VBP = 5;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;
  localparam int CW = 8;
  localparam int PIPE = 3;
  localparam int NCYC = 4 + 7 * FT;
  localparam int RST_AT = 4 + 2 * FT + 3011;

  logic          clk_pix = 1'b0;
  logic          rst;
  logic [1:0]    pattern_mode;
  logic [2:0]    pix_r;
  logic [2:0]    pix_g;
  logic [1:0]    pix_b;
  logic [CW-1:0] sx;
  logic [CW-1:0] sy;
  logic          de;
  logic          frame_start;
  logic          vga_hsync;
  logic          vga_vsync;
  logic [2:0]    vga_r;
  logic [2:0]    vga_g;
  logic [1:0]    vga_b;

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_POL(HPOL), .V_POL(VPOL), .CW(CW),
    .RW(3), .GW(3), .BW(2), .PIPE(PIPE)
  ) dut (
    .clk_pix(clk_pix),
    .rst(rst),
    .pattern_mode(pattern_mode),
    .pix_r(pix_r),
    .pix_g(pix_g),
    .pix_b(pix_b),
    .sx(sx),
    .sy(sy),
    .de(de),
    .frame_start(frame_start),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    bit v;
    int x;
    int y;
    int mode;
  } ent_t;

  typedef struct {
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic          de;
    logic          fs;
    logic          hs;
    logic          vs;
    logic [2:0]    r;
    logic [2:0]    g;
    logic [1:0]    b;
  } exp_t;

  ent_t hist[$];
  exp_t sbq[$];
  int   p;
  int   fmode;
  int   frame_no;
  int   errors;
  int   checks;

  task automatic reset_hist();
    ent_t z;
    z = '{v: 1'b0, x: 0, y: 0, mode: 0};
    hist.delete();
    for (int i = 0; i < PIPE; i++)
      hist.push_back(z);
  endtask

  // expected response for the edge that is happening now
  task automatic model_step();
    exp_t e;
    ent_t cur;
    ent_t al;
    int   bar;
    bit   on;
    e = '{sx: '0, sy: '0, de: 1'b0, fs: 1'b0, hs: ~HPOL, vs: ~VPOL,
          r: '0, g: '0, b: '0};
    if (rst) begin
      p = -1;
      fmode = 0;
      reset_hist();
    end else begin
      cur.v = (p >= 0);
      cur.x = (p >= 0) ? p % HT : 0;
      cur.y = (p >= 0) ? (p / HT) % VT : 0;
      if (p >= 0 && p % FT == 0)
        fmode = int'(pattern_mode);
      cur.mode = fmode;
      hist.push_back(cur);
      al = hist.pop_front();
      if (al.v && al.x >= HA + HFP && al.x < HA + HFP + HSW)
        e.hs = HPOL;
      if (al.v && al.y >= VA + VFP && al.y < VA + VFP + VSW)
        e.vs = VPOL;
      if (al.v && al.x < HA && al.y < VA) begin
        case (al.mode)
          0: begin
            e.r = pix_r;
            e.g = pix_g;
            e.b = pix_b;
          end
          1: begin
            e.r = 3'd7;
            e.g = 3'd7;
            e.b = 2'd3;
          end
          2: begin
            bar = (al.x * 8) / HA;
            e.r = ((bar / 4) % 2 == 1) ? 3'd7 : 3'd0;
            e.g = ((bar / 2) % 2 == 1) ? 3'd7 : 3'd0;
            e.b = (bar % 2 == 1) ? 2'd3 : 2'd0;
          end
          default: begin
            on = ((al.x / 32) % 2) != ((al.y / 32) % 2);
            e.r = on ? 3'd7 : 3'd0;
            e.g = on ? 3'd7 : 3'd0;
            e.b = on ? 2'd3 : 2'd0;
          end
        endcase
      end
      p = p + 1;
      e.sx = CW'(p % HT);
      e.sy = CW'((p / HT) % VT);
      e.de = ((p % HT) < HA) && (((p / HT) % VT) < VA);
      e.fs = (p % FT == 0);
    end
    sbq.push_back(e);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    frame_no = 0;
    p = -1;
    fmode = 0;
    rst = 1'b1;
    pattern_mode = 2'd0;
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    reset_hist();
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk_pix);
      model_step();
      #1;
      rst = (n < 3) || (n >= RST_AT && n < RST_AT + 3);
      pix_r = 3'($urandom_range(0, 7));
      pix_g = 3'($urandom_range(0, 7));
      pix_b = 2'($urandom_range(0, 3));
      if (!rst && p >= 0 && p % FT == 0) begin
        pattern_mode = 2'(frame_no + 1);
        frame_no++;
      end else begin
        pattern_mode = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk_pix);
    @(negedge clk_pix);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0",
               sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_pix);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if ({sx, sy, de, frame_start} !== {e.sx, e.sy, e.de, e.fs}) begin
          errors++;
          $display("FAIL cnt @%0t: sx=%0d sy=%0d de=%b fs=%b, required sx=%0d sy=%0d de=%b fs=%b",
                   $time, sx, sy, de, frame_start, e.sx, e.sy, e.de, e.fs);
        end
        checks++;
        if ({vga_hsync, vga_vsync} !== {e.hs, e.vs}) begin
          errors++;
          $display("FAIL sync @%0t: hs=%b vs=%b, required hs=%b vs=%b",
                   $time, vga_hsync, vga_vsync, e.hs, e.vs);
        end
        checks++;
        if ({vga_r, vga_g, vga_b} !== {e.r, e.g, e.b}) begin
          errors++;
          $display("FAIL rgb @%0t: r=%0d g=%0d b=%0d, required r=%0d g=%0d b=%0d",
                   $time, vga_r, vga_g, vga_b, e.r, e.g, e.b);
        end
      end
    end
  end

endmodule
